// File: rtl/cnn_stage_sequencer.sv
// Control FSM for one CNN layer: runs conv then max-pool per image over a batch,
// hands each pooled map to the consumer, and traps a hung engine with a watchdog.
module cnn_stage_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_images,
  input  logic             abort,
  output logic             conv_start,
  input  logic             conv_done,
  output logic             pool_start,
  input  logic             pool_done,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [CNT_W-1:0] img_idx,
  output logic             busy,
  output logic             batch_done,
  output logic             timeout_err
);

  localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV_GO,
    S_CONV_WAIT,
    S_POOL_GO,
    S_POOL_WAIT,
    S_OUT,
    S_FIN,
    S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;

  logic conv_start_q, conv_start_d;
  logic pool_start_q, pool_start_d;
  logic result_valid_q, result_valid_d;
  logic busy_q, busy_d;
  logic batch_done_q, batch_done_d;
  logic timeout_err_q, timeout_err_d;

  // State, counters and registered Moore outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      cnt_q          <= '0;
      wd_q           <= '0;
      conv_start_q   <= 1'b0;
      pool_start_q   <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      batch_done_q   <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      wd_q           <= wd_d;
      conv_start_q   <= conv_start_d;
      pool_start_q   <= pool_start_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      batch_done_q   <= batch_done_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  // Next-state: abort beats everything; a done on the last watchdog cycle beats the timeout
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    if (abort) begin
      state_d = S_IDLE;
      idx_d   = '0;
      wd_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && (num_images != '0)) begin
            cnt_d   = num_images;
            idx_d   = '0;
            state_d = S_CONV_GO;
          end
        end
        S_CONV_GO: begin
          wd_d    = '0;
          state_d = S_CONV_WAIT;
        end
        S_CONV_WAIT: begin
          if (conv_done)            state_d = S_POOL_GO;
          else if (wd_q == WD_LAST) state_d = S_ERR;
          else                      wd_d    = wd_q + WD_W'(1);
        end
        S_POOL_GO: begin
          wd_d    = '0;
          state_d = S_POOL_WAIT;
        end
        S_POOL_WAIT: begin
          if (pool_done)            state_d = S_OUT;
          else if (wd_q == WD_LAST) state_d = S_ERR;
          else                      wd_d    = wd_q + WD_W'(1);
        end
        S_OUT: begin
          if (result_ready) begin
            if (idx_q == cnt_q - CNT_W'(1)) begin
              state_d = S_FIN;
            end else begin
              idx_d   = idx_q + CNT_W'(1);
              state_d = S_CONV_GO;
            end
          end
        end
        S_FIN:   state_d = S_IDLE;
        S_ERR:   state_d = S_ERR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state so the flops present it with that state
  always_comb begin
    conv_start_d   = (state_d == S_CONV_GO);
    pool_start_d   = (state_d == S_POOL_GO);
    result_valid_d = (state_d == S_OUT);
    busy_d         = (state_d != S_IDLE);
    batch_done_d   = (state_d == S_FIN);
    timeout_err_d  = (state_d == S_ERR);
  end

  assign conv_start   = conv_start_q;
  assign pool_start   = pool_start_q;
  assign result_valid = result_valid_q;
  assign img_idx      = idx_q;
  assign busy         = busy_q;
  assign batch_done   = batch_done_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_cnn_stage_sequencer.sv
// Bench for cnn_stage_sequencer: engine/consumer responder, event-timeline reference
// model, a table of batch scenarios, random batches and hand-driven corner cases.
module tb_cnn_stage_sequencer;

  localparam int unsigned TO = 16;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] num_images;
  logic          abort;
  logic          conv_start, conv_done, pool_start, pool_done;
  logic          result_valid, result_ready, busy, batch_done, timeout_err;
  logic [CW-1:0] img_idx;

  logic auto_en;
  logic man_conv_done, man_pool_done, man_ready;
  logic rsp_conv_done = 1'b0, rsp_pool_done = 1'b0, rsp_ready = 1'b0;

  assign conv_done    = auto_en ? rsp_conv_done : man_conv_done;
  assign pool_done    = auto_en ? rsp_pool_done : man_pool_done;
  assign result_ready = auto_en ? rsp_ready     : man_ready;

  cnn_stage_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_images(num_images), .abort(abort),
    .conv_start(conv_start), .conv_done(conv_done), .pool_start(pool_start),
    .pool_done(pool_done), .result_valid(result_valid), .result_ready(result_ready),
    .img_idx(img_idx), .busy(busy), .batch_done(batch_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-image engine latencies and consumer stall, indexed by image number
  int lc_a[256], lp_a[256], st_a[256];

  int epoch = 0, seen_epoch = 0;
  int n_conv = 0, conv_due = -1, pool_due = -1, v_start = 0;
  logic prev_valid = 1'b0, prev_busy = 1'b0;
  logic [CW-1:0] prev_idx = '0;
  int q_conv[$], q_pool[$], q_hs[$], q_hsidx[$], q_bd[$], q_idle[$];
  int err_cyc = -1, v_cycles = 0, idx_bad = 0;

  // Responder and event logger, running on the falling edge
  always @(negedge clk) begin
    int   cur;
    logic eff_ready;
    if (epoch != seen_epoch) begin
      seen_epoch = epoch;
      n_conv = 0; conv_due = -1; pool_due = -1; v_start = 0;
      q_conv.delete(); q_pool.delete(); q_hs.delete(); q_hsidx.delete();
      q_bd.delete(); q_idle.delete();
      err_cyc = -1; v_cycles = 0; idx_bad = 0;
    end
    rsp_conv_done = (cyc == conv_due);
    rsp_pool_done = (cyc == pool_due);
    if (conv_start) begin
      q_conv.push_back(cyc);
      conv_due = cyc + lc_a[n_conv % 256];
      n_conv++;
    end
    cur = (n_conv > 0) ? (n_conv - 1) % 256 : 0;
    if (pool_start) begin
      q_pool.push_back(cyc);
      pool_due = cyc + lp_a[cur];
    end
    if (result_valid && !prev_valid) v_start = cyc;
    rsp_ready = result_valid && (cyc >= v_start + st_a[cur]);
    eff_ready = auto_en ? rsp_ready : man_ready;
    if (result_valid) v_cycles++;
    if (result_valid && prev_valid && (img_idx != prev_idx)) idx_bad++;
    if (result_valid && eff_ready) begin
      q_hs.push_back(cyc);
      q_hsidx.push_back(int'(img_idx));
    end
    if (batch_done) q_bd.push_back(cyc);
    if (timeout_err && (err_cyc < 0)) err_cyc = cyc;
    if (prev_busy && !busy) q_idle.push_back(cyc);
    prev_valid = result_valid;
    prev_busy  = busy;
    prev_idx   = img_idx;
  end

  task automatic bump_epoch();
    @(posedge clk);
    #1 epoch++;
  endtask

  task automatic set_all(input int lc, input int lp, input int st);
    for (int i = 0; i < 256; i++) begin
      lc_a[i] = lc; lp_a[i] = lp; st_a[i] = st;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_conv_start"}, conv_start, 0);
    chk({tag, "_pool_start"}, pool_start, 0);
    chk({tag, "_result_valid"}, result_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_batch_done"}, batch_done, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
    chk({tag, "_img_idx"}, img_idx, 0);
  endtask

  // Runs one batch under the responder and checks the event timeline against the model
  task automatic run_batch(input int n, input string tag, output int rel_end);
    int acc, g, ps, v, h, exp_err, exp_bd, exp_idle, vc, bad, act_bd, act_idle;
    int e_conv[$], e_pool[$], e_hs[$];
    bump_epoch();
    @(negedge clk);
    start = 1'b1; num_images = CW'(n); acc = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk); #1;
      if ((q_idle.size() > 0) || (err_cyc >= 0)) break;
    end
    chk({tag, "_ended"}, int'((q_idle.size() > 0) || (err_cyc >= 0)), 1);

    exp_err = -1; exp_bd = -1; exp_idle = -1; vc = 0; g = acc + 1;
    for (int i = 0; i < n; i++) begin
      e_conv.push_back(g);
      if (lc_a[i] > int'(TO)) begin exp_err = g + int'(TO) + 1; break; end
      ps = g + lc_a[i] + 1;
      e_pool.push_back(ps);
      if (lp_a[i] > int'(TO)) begin exp_err = ps + int'(TO) + 1; break; end
      v = ps + lp_a[i] + 1;
      h = v + st_a[i];
      e_hs.push_back(h);
      vc += st_a[i] + 1;
      g = h + 1;
      if (i == n - 1) begin exp_bd = h + 1; exp_idle = h + 2; end
    end

    chk({tag, "_conv_n"}, q_conv.size(), e_conv.size());
    bad = 0;
    foreach (e_conv[i]) if ((i >= q_conv.size()) || (q_conv[i] != e_conv[i])) bad++;
    chk({tag, "_conv_times_bad"}, bad, 0);
    chk({tag, "_pool_n"}, q_pool.size(), e_pool.size());
    bad = 0;
    foreach (e_pool[i]) if ((i >= q_pool.size()) || (q_pool[i] != e_pool[i])) bad++;
    chk({tag, "_pool_times_bad"}, bad, 0);
    chk({tag, "_accept_n"}, q_hs.size(), e_hs.size());
    bad = 0;
    foreach (e_hs[i]) if ((i >= q_hs.size()) || (q_hs[i] != e_hs[i]) || (q_hsidx[i] != i)) bad++;
    chk({tag, "_accept_bad"}, bad, 0);
    act_bd   = (q_bd.size() == 1) ? q_bd[0] : ((q_bd.size() == 0) ? -1 : -2);
    act_idle = (q_idle.size() > 0) ? q_idle[0] : -1;
    chk({tag, "_batch_done_cyc"}, act_bd, exp_bd);
    chk({tag, "_idle_cyc"}, act_idle, exp_idle);
    chk({tag, "_err_cyc"}, err_cyc, exp_err);
    chk({tag, "_valid_cycles"}, v_cycles, vc);
    chk({tag, "_idx_unstable"}, idx_bad, 0);
    rel_end = (q_bd.size() > 0) ? q_bd[0] - acc : ((err_cyc >= 0) ? err_cyc - acc : -1);

    if (err_cyc >= 0) begin
      @(negedge clk);
      chk({tag, "_err_sticky"}, timeout_err, 1);
      chk({tag, "_err_busy"}, busy, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk({tag, "_abort_err_clr"}, timeout_err, 0);
      chk({tag, "_abort_idle"}, busy, 0);
    end
  endtask

  typedef struct {
    int n; int lc; int lp; int st;
    int e_conv; int e_pool; int e_bd; int e_rel;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int rel, seen, n;
    tbl[0] = '{1,   10, 6,  0, 1,   1,   1, 20};
    tbl[1] = '{3,   3,  2,  4, 3,   3,   1, 37};
    tbl[2] = '{2,   16, 16, 1, 2,   2,   1, 73};
    tbl[3] = '{2,   17, 5,  0, 1,   0,   0, 18};
    tbl[4] = '{1,   4,  17, 0, 1,   1,   0, 23};
    tbl[5] = '{255, 1,  1,  0, 255, 255, 1, 1276};

    reset = 1'b0; start = 1'b0; abort = 1'b0; num_images = '0;
    man_conv_done = 1'b0; man_pool_done = 1'b0; man_ready = 1'b0; auto_en = 1'b0;
    set_all(1, 1, 0);
    repeat (3) @(negedge clk);
    chk_reset_outputs("in_reset");
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", busy, 0);

    // start with zero images is ignored
    start = 1'b1; num_images = '0;
    @(negedge clk);
    start = 1'b0;
    chk("zero_cnt_busy", busy, 0);
    chk("zero_cnt_conv_start", conv_start, 0);

    // stray dones in IDLE
    man_conv_done = 1'b1; man_pool_done = 1'b1;
    @(negedge clk);
    man_conv_done = 1'b0; man_pool_done = 1'b0;
    chk("idle_spur_busy", busy, 0);
    chk("idle_spur_pool_start", pool_start, 0);

    // single image by hand: stray pool_done in conv phase, start while busy, stray dones in OUT
    start = 1'b1; num_images = CW'(1);
    @(negedge clk);
    chk("man_conv_start", conv_start, 1);
    chk("man_busy", busy, 1);
    num_images = CW'(5); man_pool_done = 1'b1;
    @(negedge clk);
    chk("man_conv_pulse_end", conv_start, 0);
    @(negedge clk);
    chk("man_no_pool_start", pool_start, 0);
    start = 1'b0; man_pool_done = 1'b0; man_conv_done = 1'b1;
    @(negedge clk);
    man_conv_done = 1'b0;
    chk("man_pool_start", pool_start, 1);
    @(negedge clk);
    man_pool_done = 1'b1;
    @(negedge clk);
    man_pool_done = 1'b0;
    chk("man_valid", result_valid, 1);
    man_conv_done = 1'b1; man_pool_done = 1'b1;
    @(negedge clk);
    man_conv_done = 1'b0; man_pool_done = 1'b0;
    chk("man_valid_held", result_valid, 1);
    chk("man_out_no_conv_start", conv_start, 0);
    man_ready = 1'b1;
    @(negedge clk);
    man_ready = 1'b0;
    chk("man_batch_done", batch_done, 1);
    chk("man_valid_drop", result_valid, 0);
    @(negedge clk);
    chk("man_idle_busy", busy, 0);
    chk("man_bd_pulse", batch_done, 0);

    // abort while presenting a result
    start = 1'b1; num_images = CW'(2);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    man_conv_done = 1'b1;
    @(negedge clk);
    man_conv_done = 1'b0;
    @(negedge clk);
    man_pool_done = 1'b1;
    @(negedge clk);
    man_pool_done = 1'b0;
    chk("abort_in_out", result_valid, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", result_valid, 0);
    chk("abort_idx", img_idx, 0);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (batch_done || conv_start) seen++;
    end
    chk("abort_no_pulses", seen, 0);

    auto_en = 1'b1;
    foreach (tbl[i]) begin
      set_all(tbl[i].lc, tbl[i].lp, tbl[i].st);
      run_batch(tbl[i].n, $sformatf("vec%0d", i), rel);
      chk($sformatf("vec%0d_conv_pulses", i), q_conv.size(), tbl[i].e_conv);
      chk($sformatf("vec%0d_pool_pulses", i), q_pool.size(), tbl[i].e_pool);
      chk($sformatf("vec%0d_bd_pulses", i), q_bd.size(), tbl[i].e_bd);
      chk($sformatf("vec%0d_end_rel", i), rel, tbl[i].e_rel);
    end

    for (int r = 0; r < 10; r++) begin
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) begin
        lc_a[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 20)) : int'($urandom_range(1, 16));
        lp_a[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 20)) : int'($urandom_range(1, 16));
        st_a[i] = int'($urandom_range(0, 5));
      end
      run_batch(n, $sformatf("rnd%0d", r), rel);
    end

    // asynchronous reset while image 1 waits on the pool engine
    set_all(3, 10, 0);
    bump_epoch();
    @(negedge clk);
    start = 1'b1; num_images = CW'(3);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (q_pool.size() >= 2) break;
    end
    chk("rst_reached_img1_pool", q_pool.size(), 2);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    chk("rst_pre_busy", busy, 1);
    chk("rst_pre_idx", img_idx, 1);
    #1 reset = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    @(negedge clk);
    reset = 1'b1;
    set_all(3, 2, 1);
    run_batch(2, "after_rst", rel);
    chk("after_rst_bd_pulses", q_bd.size(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
